opcode_seq_rom: RTL and testbench
=================================

// Module: opcode_seq_rom
// PURPOSE
//  Parametrised microcode sequencer. Accepts a program-select command and
//  streams that program's opcodes, one per accepted beat, to the datapath
//  controller. Sits between the top-level state machine and the mult/xor
//  datapath. Generalises the fixed mult/xor opcode ROM:
//  - opcode width, program count and program length are parameters
//  - valid/ready handshake on both the command and opcode sides
//  - last/done/error flags
// PARAMETERS
//  OP_W     16  opcode width in bits
//  N_PROG   16  number of program slots; slot 0 is reserved and invalid
//  MAX_LEN  8   maximum opcodes per program
//  SEL_W    5   command select width; must satisfy 2**SEL_W >= N_PROG
//  CNT_W    4   beat counter width; must satisfy 2**CNT_W > MAX_LEN
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      reset, asynchronous, active-low
//  cmd_valid  in   1      command present
//  cmd_sel    in   SEL_W  program number
//  cmd_ready  out  1      sequencer can accept a command (high only in IDLE)
//  op_valid   out  1      op_data/op_last/op_idx are valid
//  op_ready   in   1      downstream accepts the current opcode
//  op_data    out  OP_W   opcode
//  op_idx     out  CNT_W  beat index within the program, starting at 0
//  op_last    out  1      current opcode is the last of the program
//  busy       out  1      a program is in progress
//  done       out  1      one-cycle pulse after the last opcode is accepted
//  err        out  1      one-cycle pulse when a command is rejected
// BEHAVIOUR
//  - Reset (asynchronous): state=IDLE, every output 0 except cmd_ready=1.
//    Reset mid-program aborts it immediately; no done pulse is produced.
//  - FSM states: IDLE, RUN, FIN.
//  - IDLE: a command is accepted when cmd_valid && cmd_ready.
//    - cmd_sel==0, cmd_sel>=N_PROG, or program length 0: err pulses the next
//      cycle and the FSM stays in IDLE.
//    - Otherwise: go to RUN, latch sel, load beat 0. op_valid rises on the
//      cycle after acceptance (latency 1).
//  - RUN: op_data/op_idx/op_last are registered and held stable while
//    op_valid && !op_ready. On acceptance (op_valid && op_ready):
//    - not last: the next beat is presented the following cycle; beats run
//      back-to-back when op_ready stays high.
//    - last: op_valid drops and the FSM goes to FIN.
//  - FIN: done=1 for one cycle, busy=0, then IDLE. cmd_ready is high again
//    the cycle after done.
//  - busy=1 in RUN and 0 in FIN.
//  - Commands arriving while not in IDLE are not accepted (cmd_ready=0) and
//    have no effect.
//  - op_last = (op_idx == len[sel]-1). op_idx never exceeds MAX_LEN-1.
//  - Unused opcode slots read as 0 and are never emitted.
// CONFIGURATION
//  - SEQ_STALL_EN defined: op_ready backpressure is honoured as above.
//  - SEQ_STALL_EN undefined: op_ready is ignored and treated as 1. One
//    opcode is emitted per cycle; the port still exists.
// STRUCTURE
//  Package opseq_pkg holds:
//  - state enum {IDLE, RUN, FIN}
//  - PROG_LEN[N_PROG] lengths
//  - PROG_OPS[N_PROG][MAX_LEN] opcode table
//  - named program ids: MUL128..MUL576 = 1..5, XOR128..XOR384 = 6..8
//  Sub-module opseq_table: combinational lookup (sel, idx) -> {op, len},
//  parametrised like the parent. FSM, counter and output registers live in
//  opcode_seq_rom.
// TESTING
//  Build with SEQ_STALL_EN unless noted; op_ready=1 unless noted.
//  1. sel=1 -> one beat op_data=16'h0050, op_idx=0, op_last=1; done pulses
//     2 cycles after acceptance.
//  2. sel=5 -> op_data 0050, 0098, 00D2, 011A, 0154 on consecutive cycles;
//     op_last only on 0154.
//  3. sel=7, op_ready=0 for 3 cycles on beat 0 -> 01E0 held for 4 cycles,
//     then 03E2; done follows it.
//  4. sel=0, then sel=20 -> err pulses each time; op_valid stays 0 and
//     cmd_ready stays 1.
//  5. sel=8 with cmd_valid also held high during RUN -> only 01E0, 03E2,
//     05E4 emitted; no second program starts until after done.
//  6. rst_n low at beat 2 of sel=4 -> all outputs 0 at once, cmd_ready=1,
//     no done; a new sel=2 then emits 0050, 0098. Repeat with
//     SEQ_STALL_EN undefined and op_ready=0: beats still advance every cycle.

Source files
------------

// File: rtl/opseq_pkg.sv
// Shared types and the microcode program tables for the opcode sequencer.
// Holds the program lengths, opcode contents and named program ids.
package opseq_pkg;

    localparam int PKG_OP_W    = 16;
    localparam int PKG_N_PROG  = 16;
    localparam int PKG_MAX_LEN = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    localparam int MUL128 = 1;
    localparam int MUL256 = 2;
    localparam int MUL384 = 3;
    localparam int MUL512 = 4;
    localparam int MUL576 = 5;
    localparam int XOR128 = 6;
    localparam int XOR256 = 7;
    localparam int XOR384 = 8;

    // Slot 0 is reserved, so its length is 0 and it is always rejected.
    localparam logic [3:0] PROG_LEN [PKG_N_PROG] = '{
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1, 4'd2,
        4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0
    };

    localparam logic [PKG_OP_W-1:0] PROG_OPS [PKG_N_PROG][PKG_MAX_LEN] = '{
        '{default: 16'h0000},
        '{16'h0050, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
        '{16'h0050, 16'h0098, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
        '{16'h0050, 16'h0098, 16'h00D2, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
        '{16'h0050, 16'h0098, 16'h00D2, 16'h011A, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
        '{16'h0050, 16'h0098, 16'h00D2, 16'h011A, 16'h0154, 16'h0000, 16'h0000, 16'h0000},
        '{16'h01E0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
        '{16'h01E0, 16'h03E2, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
        '{16'h01E0, 16'h03E2, 16'h05E4, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
        '{default: 16'h0000},
        '{default: 16'h0000},
        '{default: 16'h0000},
        '{default: 16'h0000},
        '{default: 16'h0000},
        '{default: 16'h0000},
        '{default: 16'h0000}
    };

endpackage

// File: rtl/opseq_table.sv
// Combinational program lookup: (sel, idx) -> opcode and program length.
// Out-of-range selects and beats past the program length read as 0.
module opseq_table
    import opseq_pkg::*;
#(
    parameter int OP_W    = 16,
    parameter int N_PROG  = 16,
    parameter int MAX_LEN = 8,
    parameter int SEL_W   = 5,
    parameter int CNT_W   = 4
) (
    input  logic [SEL_W-1:0] sel,
    input  logic [CNT_W-1:0] idx,
    output logic [OP_W-1:0]  op,
    output logic [CNT_W-1:0] len
);

    logic [N_PROG-1:0] hit;

    for (genvar gi = 0; gi < N_PROG; gi++) begin : g_hit
        assign hit[gi] = ({1'b0, sel} == (SEL_W+1)'(gi));
    end

    always_comb begin
        op  = '0;
        len = '0;
        for (int p = 1; p < N_PROG && p < PKG_N_PROG; p++) begin
            if (hit[p]) begin
                len = CNT_W'(PROG_LEN[p]);
                for (int b = 0; b < MAX_LEN && b < PKG_MAX_LEN; b++) begin
                    if (idx == CNT_W'(b) && CNT_W'(b) < len) begin
                        op = OP_W'(PROG_OPS[p][b]);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/opcode_seq_rom.sv
// Microcode sequencer: accepts a program select and streams its opcodes.
// Define SEQ_STALL_EN to honour op_ready backpressure; otherwise one beat per cycle.
module opcode_seq_rom
    import opseq_pkg::*;
#(
    parameter int OP_W    = 16,
    parameter int N_PROG  = 16,
    parameter int MAX_LEN = 8,
    parameter int SEL_W   = 5,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [SEL_W-1:0] cmd_sel,
    output logic             cmd_ready,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [OP_W-1:0]  op_data,
    output logic [CNT_W-1:0] op_idx,
    output logic             op_last,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_FIN  = FIN;

    logic [1:0]       state_reg;
    logic [SEL_W-1:0] sel_reg;
    logic [CNT_W-1:0] idx_reg;
    logic [OP_W-1:0]  data_reg;
    logic             valid_reg;
    logic             last_reg;
    logic             err_reg;

    logic [SEL_W-1:0] lk_sel;
    logic [CNT_W-1:0] lk_idx;
    logic [CNT_W-1:0] lk_len;
    logic [OP_W-1:0]  lk_op;
    logic             ready_eff;
    logic             sel_ok;

`ifdef SEQ_STALL_EN
    assign ready_eff = op_ready;
`else
    logic unused_op_ready;
    assign unused_op_ready = op_ready;
    assign ready_eff       = 1'b1;
`endif

    // In IDLE the table looks up beat 0 of the incoming command; in RUN it
    // prefetches the beat after the one currently presented.
    assign lk_sel = (state_reg == S_IDLE) ? cmd_sel : sel_reg;
    assign lk_idx = (state_reg == S_IDLE) ? '0 : idx_reg + CNT_W'(1);

    opseq_table #(
        .OP_W    (OP_W),
        .N_PROG  (N_PROG),
        .MAX_LEN (MAX_LEN),
        .SEL_W   (SEL_W),
        .CNT_W   (CNT_W)
    ) u_table (
        .sel (lk_sel),
        .idx (lk_idx),
        .op  (lk_op),
        .len (lk_len)
    );

    assign sel_ok = (cmd_sel != '0) && ({1'b0, cmd_sel} < (SEL_W+1)'(N_PROG)) && (lk_len != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            sel_reg   <= '0;
            idx_reg   <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (sel_ok) begin
                            state_reg <= S_RUN;
                            sel_reg   <= cmd_sel;
                            idx_reg   <= '0;
                            data_reg  <= lk_op;
                            last_reg  <= (lk_len == CNT_W'(1));
                            valid_reg <= 1'b1;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (valid_reg && ready_eff) begin
                        if (last_reg) begin
                            state_reg <= S_FIN;
                            valid_reg <= 1'b0;
                            last_reg  <= 1'b0;
                            data_reg  <= '0;
                            idx_reg   <= '0;
                        end else begin
                            idx_reg  <= lk_idx;
                            data_reg <= lk_op;
                            last_reg <= (lk_idx == lk_len - CNT_W'(1));
                        end
                    end
                end
                S_FIN:   state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_reg == S_IDLE);
    assign busy      = (state_reg == S_RUN);
    assign done      = (state_reg == S_FIN);
    assign err       = err_reg;
    assign op_valid  = valid_reg;
    assign op_data   = data_reg;
    assign op_idx    = idx_reg;
    assign op_last   = last_reg;

endmodule

// File: tb/tb_opcode_seq_rom.sv
// Self-checking bench for opcode_seq_rom against a program-list reference model.
// Adapts its expectations to whether SEQ_STALL_EN is defined.
module tb_opcode_seq_rom;

`ifdef SEQ_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [4:0]  cmd_sel = '0;
    logic        op_ready = 1'b1;
    logic        cmd_ready, op_valid, op_last, busy, done, err;
    logic [15:0] op_data;
    logic [3:0]  op_idx;

    int checks = 0;
    int errors = 0;

    logic [15:0] mul_ops [5] = '{16'h0050, 16'h0098, 16'h00D2, 16'h011A, 16'h0154};
    logic [15:0] xor_ops [3] = '{16'h01E0, 16'h03E2, 16'h05E4};

    opcode_seq_rom dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_sel   (cmd_sel),
        .cmd_ready (cmd_ready),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_data   (op_data),
        .op_idx    (op_idx),
        .op_last   (op_last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Programs 1..5 are growing prefixes of the mult list, 6..8 of the xor list.
    function automatic int model_len(input int sel);
        if (sel >= 1 && sel <= 5) return sel;
        if (sel >= 6 && sel <= 8) return sel - 5;
        return 0;
    endfunction

    function automatic logic [15:0] model_op(input int sel, input int k);
        if (sel <= 5) return mul_ops[k];
        return xor_ops[k];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        op_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({cmd_ready, op_valid, busy, done, err, op_data, op_idx, op_last} !== {5'b10000, 16'h0, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold: got %b %h %h %b want 10000 0000 0 0",
                     {cmd_ready, op_valid, busy, done, err}, op_data, op_idx, op_last);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({cmd_ready, op_valid, busy, done, err} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_release: flags got %b want 10000", {cmd_ready, op_valid, busy, done, err});
        end
        $display("reset: checked idle outputs");
    endtask

    // stall_mode: 0 = always ready, 1 = random ready, 2 = three stalls on beat 0
    task automatic test_program(input int sel, input int stall_mode, input bit hold);
        int len = model_len(sel);
        int b = 0;
        int cyc = 0;
        int stalls = 0;
        bit rdy;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_pre sel=%0d: got %b want 1", sel, cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_sel = 5'(sel);
        op_ready = 1'b1;
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
        while (b < len && cyc < 100) begin
            checks++;
            if ({cmd_ready, op_valid, busy, done, err} !== 5'b01100) begin
                errors++;
                $display("FAIL run_flags sel=%0d beat=%0d: got %b want 01100",
                         sel, b, {cmd_ready, op_valid, busy, done, err});
            end
            checks++;
            if ({op_data, op_idx, op_last} !== {model_op(sel, b), 4'(b), (b == len - 1)}) begin
                errors++;
                $display("FAIL beat sel=%0d beat=%0d: got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                         sel, b, op_data, op_idx, op_last, model_op(sel, b), b, (b == len - 1));
            end
            case (stall_mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = !(b == 0 && stalls < 3);
            endcase
            if (!rdy) stalls++;
            op_ready = rdy;
            if (hold) cmd_sel = 5'($urandom);
            if (rdy || !STALL) b++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (b < len) begin
            errors++;
            $display("FAIL timeout sel=%0d: got %0d beats want %0d", sel, b, len);
        end
        checks++;
        if ({cmd_ready, op_valid, busy, done, err} !== 5'b00010) begin
            errors++;
            $display("FAIL fin_flags sel=%0d: got %b want 00010", sel, {cmd_ready, op_valid, busy, done, err});
        end
        cmd_valid = 1'b0;
        op_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({cmd_ready, op_valid, busy, done, err} !== 5'b10000) begin
            errors++;
            $display("FAIL post_done sel=%0d: got %b want 10000", sel, {cmd_ready, op_valid, busy, done, err});
        end
        $display("program sel=%0d len=%0d stalls=%0d hold=%0d cycles=%0d", sel, len, stalls, hold, cyc);
    endtask

    task automatic test_invalid();
        int sels [6] = '{0, 20, 9, 15, 31, 0};
        sels[5] = int'($urandom_range(9, 31));
        for (int i = 0; i < 6; i++) begin
            cmd_valid = 1'b1;
            cmd_sel = 5'(sels[i]);
            @(negedge clk);
            checks++;
            if ({cmd_ready, op_valid, busy, done, err} !== 5'b10001) begin
                errors++;
                $display("FAIL err_pulse sel=%0d: got %b want 10001", sels[i], {cmd_ready, op_valid, busy, done, err});
            end
            cmd_valid = 1'b0;
            @(negedge clk);
            checks++;
            if ({cmd_ready, op_valid, busy, done, err} !== 5'b10000) begin
                errors++;
                $display("FAIL err_clear sel=%0d: got %b want 10000", sels[i], {cmd_ready, op_valid, busy, done, err});
            end
            $display("invalid sel=%0d rejected", sels[i]);
        end
    endtask

    task automatic test_reset_midprog();
        int cyc = 0;
        cmd_valid = 1'b1;
        cmd_sel = 5'd4;
        op_ready = STALL ? 1'b1 : 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (op_idx !== 4'd2 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if ({op_valid, op_data, op_idx} !== {1'b1, 16'h00D2, 4'd2}) begin
            errors++;
            $display("FAIL beat2_before_reset: got valid=%b data=%h idx=%0d want 1 00d2 2", op_valid, op_data, op_idx);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, op_valid, busy, done, err, op_data, op_idx, op_last} !== {5'b10000, 16'h0, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got %b %h %h %b want 10000 0000 0 0",
                     {cmd_ready, op_valid, busy, done, err}, op_data, op_idx, op_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({cmd_ready, op_valid, busy, done, err} !== 5'b10000) begin
            errors++;
            $display("FAIL no_done_after_reset: got %b want 10000", {cmd_ready, op_valid, busy, done, err});
        end
        op_ready = 1'b1;
        $display("reset mid-program sel=4 at beat 2 after %0d cycles", cyc);
    endtask

    initial begin
        test_reset();
        test_program(1, 0, 1'b0);
        test_program(5, 0, 1'b0);
        test_program(7, 2, 1'b0);
        test_invalid();
        test_program(8, 0, 1'b1);
        test_reset_midprog();
        test_program(2, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            test_program(int'($urandom_range(1, 8)), 1, 1'($urandom_range(0, 1)));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
